// File: rtl/sd_cmd_master_if.sv
// Bundles the host request/completion handshake and the CMD physical-block
// handshake of the SD command sequencer into one port.
// The master modport is the sequencer's view. The slave modport is the view
// of whatever sits on the other side: host logic, phys block or a testbench.
interface sd_cmd_master_if;
  // Host request side
  logic         new_command;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_argument;
  logic [1:0]   resp_type;
  logic         host_ack;

  // Host completion side
  logic         busy;
  logic         command_complete;
  logic         command_timeout;
  logic [135:0] response;

  // CMD physical block side
  logic         strobe_out;
  logic         ack_out;
  logic         idle_out;
  logic         expect_resp;
  logic         resp_long;
  logic [39:0]  cmd_to_send;
  logic         phys_done;
  logic [135:0] response_in;

  modport master (
    input  new_command, cmd_index, cmd_argument, resp_type, host_ack,
           phys_done, response_in,
    output busy, command_complete, command_timeout, response,
           strobe_out, ack_out, idle_out, expect_resp, resp_long, cmd_to_send
  );

  modport slave (
    output new_command, cmd_index, cmd_argument, resp_type, host_ack,
           phys_done, response_in,
    input  busy, command_complete, command_timeout, response,
           strobe_out, ack_out, idle_out, expect_resp, resp_long, cmd_to_send
  );
endinterface

// File: rtl/sd_cmd_master.sv
// Host-side sequencer for the SD CMD line. It takes one command request at a
// time and formats the 40-bit command word. It strobes the CMD physical block
// and supervises the transfer with a timeout counter, then returns the
// captured response and its status through a four-phase handshake with the
// host. Every output comes straight from a register, so no input has a
// combinational path to an output.
module sd_cmd_master #(
  parameter int TIMEOUT = 64,  // SD clocks allowed in SEND, at least 2
  parameter int CNT_W   = 16   // timeout counter width, must hold TIMEOUT
) (
  input logic             sd_clock,
  input logic             reset,
  sd_cmd_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  // The count reached on the last cycle of SEND before a timeout is declared.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic         busy_q;
  logic         complete_q;
  logic         timeout_q;
  logic [135:0] response_q;
  logic         strobe_q;
  logic         ack_q;
  logic         idle_q;
  logic         expect_q;
  logic         long_q;
  logic [39:0]  cmd_q;

  // Sequencer FSM. Each output is updated on the same edge that enters the
  // state where that output takes its new value, so every output comes
  // straight from a flop.
  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
      timeout_q  <= 1'b0;
      response_q <= '0;
      strobe_q   <= 1'b0;
      ack_q      <= 1'b0;
      idle_q     <= 1'b1;
      expect_q   <= 1'b0;
      long_q     <= 1'b0;
      cmd_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A held host_ack from the previous transaction blocks a restart
          // until the host has released it.
          if (bus.new_command && !bus.host_ack) begin
            state_q    <= LOAD;
            busy_q     <= 1'b1;
            idle_q     <= 1'b0;
            cmd_q      <= {2'b01, bus.cmd_index, bus.cmd_argument};
            expect_q   <= (bus.resp_type != 2'b00);
            long_q     <= (bus.resp_type == 2'b10);
            response_q <= '0;
          end
        end
        LOAD: begin
          cnt_q    <= '0;
          strobe_q <= 1'b1;
          state_q  <= SEND;
        end
        SEND: begin
          cnt_q <= cnt_q + CNT_ONE;
          // phys_done is tested first, so a completion on the final cycle
          // counts as a success.
          if (bus.phys_done) begin
            response_q <= expect_q ? bus.response_in : '0;
            timeout_q  <= 1'b0;
            strobe_q   <= 1'b0;
            ack_q      <= 1'b1;
            complete_q <= 1'b1;
            state_q    <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            response_q <= '0;
            timeout_q  <= 1'b1;
            strobe_q   <= 1'b0;
            ack_q      <= 1'b1;
            complete_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          // response stays valid after this point and is cleared at the
          // next request.
          if (bus.host_ack) begin
            complete_q <= 1'b0;
            ack_q      <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            idle_q     <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy             = busy_q;
  assign bus.command_complete = complete_q;
  assign bus.command_timeout  = timeout_q;
  assign bus.response         = response_q;
  assign bus.strobe_out       = strobe_q;
  assign bus.ack_out          = ack_q;
  assign bus.idle_out         = idle_q;
  assign bus.expect_resp      = expect_q;
  assign bus.resp_long        = long_q;
  assign bus.cmd_to_send      = cmd_q;

endmodule

// File: tb/tb_sd_cmd_master.sv
// Directed testbench for sd_cmd_master. It covers reset, the short, long,
// none and 11 response types, timeout, phys_done on the final timeout cycle,
// the host_ack handshake rules and a reset in the middle of SEND.
module tb_sd_cmd_master;
  localparam int TIMEOUT = 64;

  // Flag vector order: {busy, complete, timeout, strobe, ack, idle, expect, long}
  localparam logic [7:0] F_IDLE0    = 8'b0000_0100;
  localparam logic [135:0] R_SHORT  = 136'h3F_0011223344556677_8899AABBCCDDEE_C1;
  localparam logic [135:0] R_LONG   = 136'h81_DEADBEEF_0BADF00D_CAFEBABE_12345678;

  logic sd_clock = 1'b0;
  logic reset    = 1'b1;
  int   checks   = 0;
  int   errors   = 0;

  sd_cmd_master_if bus();

  sd_cmd_master #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .sd_clock (sd_clock),
    .reset    (reset),
    .bus      (bus)
  );

  // 100 MHz SD clock
  always #5 sd_clock = ~sd_clock;

  // Gathers the single-bit outputs into one vector for compact comparisons
  function automatic logic [7:0] flags();
    return {bus.busy, bus.command_complete, bus.command_timeout, bus.strobe_out,
            bus.ack_out, bus.idle_out, bus.expect_resp, bus.resp_long};
  endfunction

  // Advances one clock and settles just after the rising edge
  task automatic tick();
    @(posedge sd_clock);
    #1;
  endtask

  // Presents a request for one edge, after which the DUT sits in LOAD
  task automatic request(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
    bus.cmd_index    = idx;
    bus.cmd_argument = arg;
    bus.resp_type    = rt;
    bus.new_command  = 1'b1;
    tick();
    bus.new_command  = 1'b0;
    bus.cmd_index    = 6'h3F;
    bus.cmd_argument = 32'hFFFF_FFFF;
    bus.resp_type    = 2'b00;
  endtask

  // Closes the four-phase handshake from DONE back to IDLE
  task automatic release_done();
    bus.phys_done = 1'b0;
    bus.host_ack  = 1'b1;
    tick();
    bus.host_ack  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (flags() !== F_IDLE0) begin errors++; $display("[TB] FAIL reset_flags got %b want %b", flags(), F_IDLE0); end
    checks++; if (bus.response !== 136'd0) begin errors++; $display("[TB] FAIL reset_response got %h want 0", bus.response); end
    checks++; if (bus.cmd_to_send !== 40'd0) begin errors++; $display("[TB] FAIL reset_cmd got %h want 0", bus.cmd_to_send); end
    reset = 1'b0;
    tick();
    checks++; if (flags() !== F_IDLE0) begin errors++; $display("[TB] FAIL post_reset_flags got %b want %b", flags(), F_IDLE0); end
  endtask

  task automatic test_short();
    int strobes;
    strobes = 0;
    request(6'd7, 32'hA5A5_0001, 2'b01);
    checks++; if (flags() !== 8'b1000_0010) begin errors++; $display("[TB] FAIL short_load_flags got %b want %b", flags(), 8'b1000_0010); end
    checks++; if (bus.cmd_to_send !== 40'h47A5A50001) begin errors++; $display("[TB] FAIL short_cmd got %h want 47a5a50001", bus.cmd_to_send); end
    tick();
    for (int i = 0; i < 10; i++) begin
      if (bus.strobe_out) strobes++;
      if (i == 9) begin
        bus.phys_done   = 1'b1;
        bus.response_in = R_SHORT;
      end
      tick();
    end
    bus.phys_done   = 1'b0;
    bus.response_in = '1;
    checks++; if (strobes != 10) begin errors++; $display("[TB] FAIL short_strobe_cycles got %0d want 10", strobes); end
    checks++; if (flags() !== 8'b1100_1010) begin errors++; $display("[TB] FAIL short_done_flags got %b want %b", flags(), 8'b1100_1010); end
    checks++; if (bus.response !== R_SHORT) begin errors++; $display("[TB] FAIL short_response got %h want %h", bus.response, R_SHORT); end
    tick();
    checks++; if (flags() !== 8'b1100_1010) begin errors++; $display("[TB] FAIL short_done_hold got %b want %b", flags(), 8'b1100_1010); end
    release_done();
    checks++; if (flags() !== 8'b0000_0110) begin errors++; $display("[TB] FAIL short_idle_flags got %b want %b", flags(), 8'b0000_0110); end
    checks++; if (bus.response !== R_SHORT) begin errors++; $display("[TB] FAIL short_resp_held got %h want %h", bus.response, R_SHORT); end
  endtask

  task automatic test_long();
    request(6'd2, 32'h0000_0000, 2'b10);
    checks++; if (flags() !== 8'b1000_0011) begin errors++; $display("[TB] FAIL long_load_flags got %b want %b", flags(), 8'b1000_0011); end
    tick();
    bus.phys_done   = 1'b1;
    bus.response_in = R_LONG;
    tick();
    checks++; if (flags() !== 8'b1100_1011) begin errors++; $display("[TB] FAIL long_done_flags got %b want %b", flags(), 8'b1100_1011); end
    checks++; if (bus.response !== R_LONG) begin errors++; $display("[TB] FAIL long_response got %h want %h", bus.response, R_LONG); end
    release_done();
  endtask

  task automatic test_none();
    request(6'd0, 32'h1234_5678, 2'b00);
    checks++; if (flags() !== 8'b1000_0000) begin errors++; $display("[TB] FAIL none_load_flags got %b want %b", flags(), 8'b1000_0000); end
    checks++; if (bus.cmd_to_send !== 40'h4012345678) begin errors++; $display("[TB] FAIL none_cmd got %h want 4012345678", bus.cmd_to_send); end
    tick();
    bus.phys_done   = 1'b1;
    bus.response_in = R_LONG;
    tick();
    checks++; if (flags() !== 8'b1100_1000) begin errors++; $display("[TB] FAIL none_done_flags got %b want %b", flags(), 8'b1100_1000); end
    checks++; if (bus.response !== 136'd0) begin errors++; $display("[TB] FAIL none_response got %h want 0", bus.response); end
    release_done();
  endtask

  task automatic test_type11();
    request(6'd55, 32'hFFFF_0000, 2'b11);
    checks++; if (flags() !== 8'b1000_0010) begin errors++; $display("[TB] FAIL type11_load_flags got %b want %b", flags(), 8'b1000_0010); end
    checks++; if (bus.cmd_to_send !== 40'h77FFFF0000) begin errors++; $display("[TB] FAIL type11_cmd got %h want 77ffff0000", bus.cmd_to_send); end
    tick();
    bus.phys_done   = 1'b1;
    bus.response_in = R_SHORT;
    tick();
    checks++; if (bus.response !== R_SHORT) begin errors++; $display("[TB] FAIL type11_response got %h want %h", bus.response, R_SHORT); end
    release_done();
  endtask

  task automatic test_timeout();
    int strobes;
    int budget;
    strobes = 0;
    budget  = 0;
    bus.response_in = R_LONG;
    request(6'd9, 32'hCAFE_0009, 2'b01);
    tick();
    while (!bus.command_complete && budget < 200) begin
      if (bus.strobe_out) strobes++;
      tick();
      budget++;
    end
    checks++; if (budget >= 200) begin errors++; $display("[TB] FAIL timeout_wait got %0d cycles want below 200", budget); end
    checks++; if (strobes != TIMEOUT) begin errors++; $display("[TB] FAIL timeout_strobe_cycles got %0d want %0d", strobes, TIMEOUT); end
    checks++; if (flags() !== 8'b1110_1010) begin errors++; $display("[TB] FAIL timeout_done_flags got %b want %b", flags(), 8'b1110_1010); end
    checks++; if (bus.response !== 136'd0) begin errors++; $display("[TB] FAIL timeout_response got %h want 0", bus.response); end
    release_done();
    checks++; if (flags() !== 8'b0000_0110) begin errors++; $display("[TB] FAIL timeout_idle_flags got %b want %b", flags(), 8'b0000_0110); end
  endtask

  task automatic test_last_cycle();
    int strobes;
    strobes = 0;
    request(6'd17, 32'h0000_0200, 2'b01);
    tick();
    for (int i = 0; i < TIMEOUT; i++) begin
      if (bus.strobe_out) strobes++;
      if (i == TIMEOUT - 1) begin
        bus.phys_done   = 1'b1;
        bus.response_in = R_SHORT;
      end
      tick();
    end
    bus.phys_done = 1'b0;
    checks++; if (strobes != TIMEOUT) begin errors++; $display("[TB] FAIL last_strobe_cycles got %0d want %0d", strobes, TIMEOUT); end
    checks++; if (flags() !== 8'b1100_1010) begin errors++; $display("[TB] FAIL last_done_flags got %b want %b", flags(), 8'b1100_1010); end
    checks++; if (bus.response !== R_SHORT) begin errors++; $display("[TB] FAIL last_response got %h want %h", bus.response, R_SHORT); end
    release_done();
  endtask

  task automatic test_back_to_back();
    request(6'd1, 32'h0000_0011, 2'b01);
    tick();
    bus.phys_done = 1'b1;
    tick();
    bus.phys_done = 1'b0;
    // Keep host_ack and new_command high through the return to IDLE
    bus.host_ack     = 1'b1;
    bus.new_command  = 1'b1;
    bus.cmd_index    = 6'd5;
    bus.cmd_argument = 32'h0BAD_0005;
    bus.resp_type    = 2'b01;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (flags() !== 8'b0000_0110) begin errors++; $display("[TB] FAIL hold_ack_idle%0d got %b want %b", i, flags(), 8'b0000_0110); end
      tick();
    end
    checks++; if (bus.cmd_to_send !== 40'h4100000011) begin errors++; $display("[TB] FAIL hold_ack_cmd got %h want 4100000011", bus.cmd_to_send); end
    bus.host_ack = 1'b0;
    tick();
    bus.new_command = 1'b0;
    checks++; if (flags() !== 8'b1000_0010) begin errors++; $display("[TB] FAIL restart_flags got %b want %b", flags(), 8'b1000_0010); end
    checks++; if (bus.cmd_to_send !== 40'h450BAD0005) begin errors++; $display("[TB] FAIL restart_cmd got %h want 450bad0005", bus.cmd_to_send); end
    tick();
    // A request pulse during SEND must not disturb the latched command
    bus.new_command = 1'b1;
    bus.cmd_index   = 6'd63;
    tick();
    bus.new_command = 1'b0;
    checks++; if (bus.cmd_to_send !== 40'h450BAD0005) begin errors++; $display("[TB] FAIL busy_pulse_cmd got %h want 450bad0005", bus.cmd_to_send); end
    checks++; if (bus.strobe_out !== 1'b1) begin errors++; $display("[TB] FAIL busy_pulse_strobe got %b want 1", bus.strobe_out); end
    bus.phys_done = 1'b1;
    tick();
    release_done();
    tick();
    checks++; if (flags() !== 8'b0000_0110) begin errors++; $display("[TB] FAIL busy_pulse_idle got %b want %b", flags(), 8'b0000_0110); end
  endtask

  task automatic test_mid_send_reset();
    bus.response_in = R_LONG;
    request(6'd3, 32'h8765_4321, 2'b10);
    repeat (5) tick();
    checks++; if (bus.strobe_out !== 1'b1) begin errors++; $display("[TB] FAIL mid_send_strobe got %b want 1", bus.strobe_out); end
    reset = 1'b1;
    tick();
    checks++; if (flags() !== F_IDLE0) begin errors++; $display("[TB] FAIL mid_reset_flags got %b want %b", flags(), F_IDLE0); end
    checks++; if (bus.cmd_to_send !== 40'd0) begin errors++; $display("[TB] FAIL mid_reset_cmd got %h want 0", bus.cmd_to_send); end
    repeat (2) tick();
    reset = 1'b0;
    bus.phys_done = 1'b1;
    tick();
    bus.phys_done = 1'b0;
    checks++; if (flags() !== F_IDLE0) begin errors++; $display("[TB] FAIL after_reset_flags got %b want %b", flags(), F_IDLE0); end
    checks++; if (bus.response !== 136'd0) begin errors++; $display("[TB] FAIL after_reset_response got %h want 0", bus.response); end
  endtask

  // Runs every scenario in order and then prints the summary
  initial begin
    bus.new_command  = 1'b0;
    bus.cmd_index    = '0;
    bus.cmd_argument = '0;
    bus.resp_type    = '0;
    bus.host_ack     = 1'b0;
    bus.phys_done    = 1'b0;
    bus.response_in  = '0;
    test_reset();
    test_short();
    test_long();
    test_none();
    test_type11();
    test_timeout();
    test_last_cycle();
    test_back_to_back();
    test_mid_send_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
